stopwatch: RTL and testbench
============================

Name: stopwatch

Overview:
Four-digit BCD stopwatch/timer counting tenths of a second, displaying M:SS.t from 0:00.0 to 9:59.9. Start/Stop pulses control a run flag. A CountDown level selects increment or decrement. Clear zeroes the count. The block sits between the tick clock and the display driver; outputs are registered BCD digits.

Parameters:
- CLK_DIV, 1, clk cycles per tenth-of-second tick. Default 1 means clk is the 10 Hz tick. Must be ≥1.

Ports:
- clk  in  1  system clock; rising edge active.
- reset  in  1  asynchronous, active-high; clears all state.
- Start  in  1  synchronous; sampled high sets the run flag.
- Stop  in  1  synchronous; sampled high clears the run flag.
- Clear  in  1  synchronous; sampled high zeroes all digits and clears the run flag.
- CountDown  in  1  level; 1 = decrement, 0 = increment.
- Minutes  out  4  BCD 0–9.
- SecondsTens  out  4  BCD 0–5.
- SecondsOnes  out  4  BCD 0–9.
- TenthsOfSeconds  out  4  BCD 0–9.

Behaviour:
- Reset (async, active-high) behaviour:
  - All four digits become 0 immediately.
  - Run flag = 0; divider count = 0.
  - Outputs hold 0 while reset is high.
- Internal state:
  - run flag.
  - Divider counter 0..CLK_DIV-1; tick = divider at CLK_DIV-1 (tick every cycle when CLK_DIV=1).
  - Four BCD digit registers, driven directly to the outputs.
- Control priority per rising edge: Clear > Stop > Start.
  - Clear: digits ← 0, run ← 0, divider ← 0.
  - Stop (with or without Start): run ← 0; count not advanced on that edge.
  - Start alone: run ← 1; count not advanced on that edge.
  - Start while already running: no effect.
- Latency:
  - First count change occurs on the first tick edge after the edge that sampled Start.
  - With CLK_DIV=1, Start sampled at edge k gives 0:00.1 after edge k+1.
  - Stop sampled at edge k freezes the value present after edge k.
- Count step: on a tick edge with run=1 and no control input active, the value moves by one tenth. CountDown is sampled on that same edge.
- Up count:
  - Tenths 9→0 carries into SecondsOnes.
  - SecondsOnes 9→0 carries into SecondsTens.
  - SecondsTens 5→0 carries into Minutes.
  - At 9:59.9 the count saturates: holds 9:59.9, run stays 1.
- Down count:
  - Tenths 0→9 borrows from SecondsOnes.
  - SecondsOnes 0→9 borrows from SecondsTens.
  - SecondsTens 0→5 borrows from Minutes.
  - At 0:00.0 the count saturates: holds 0:00.0, run stays 1.
- CountDown may toggle mid-run; the new direction applies from the next tick. No glitch, no skipped value.
- Divider runs only while run=1. It resets to 0 on Start, Stop and Clear, so timing after Start is deterministic.
- Inputs that are X/unknown must not corrupt state. Treat Stop/Clear as inactive unless the sampled value is exactly 1.
- Digits never hold non-BCD values; invariant SecondsTens ≤ 5.

Decomposition:
- Shared package stopwatch_pkg:
  - typedef bcd_t (4-bit).
  - Constants TENTHS_MAX=9, SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_MAX=9.
- One natural sub-module, bcd_digit_counter:
  - Parameter MAX.
  - Inputs en, dir, clr.
  - Outputs digit, carry/borrow-out.
  - Instantiated four times in a ripple chain; saturation detected at the top level from the all-max / all-zero condition.

Test Plan (CLK_DIV=1):
- Reset for 20 cycles then release → all outputs 0:00.0; no counting until Start.
- Start pulsed 1 cycle, CountDown=0, run 600 cycles → 0:59.9 → next tick 1:00.0. Check carry 0:09.9→0:10.0.
- Stop pulse after 599 ticks → holds 0:59.9 for 600 more cycles. Then reset mid-value → 0:00.0 asynchronously (before the next clk edge).
- Start, count up 5990 ticks → 9:59.0. After 9 more ticks → 9:59.9; further ticks hold 9:59.9.
- From 9:59.9 raise CountDown, run 4802 ticks → 1:59.7. Check borrow 1:00.0→0:59.9 on the way. Continue to 0:00.0 and confirm it holds.
- Clear while running at 3:21.4 → next edge 0:00.0 with run=0. Start and Stop in the same cycle → run stays 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the M:SS.t BCD stopwatch.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t TENTHS_MAX   = 4'd9;
    localparam bcd_t SEC_ONES_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_MAX      = 4'd9;

    // Digit index 0 is tenths, 3 is minutes.
    function automatic bcd_t digit_max(input int idx);
        case (idx)
            0:       return TENTHS_MAX;
            1:       return SEC_ONES_MAX;
            2:       return SEC_TENS_MAX;
            default: return MIN_MAX;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_digit.sv
// One BCD digit that wraps at MAX (up) or 0 (down); co flags that the next step wraps.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic dir,
    input  logic clr,
    output bcd_t digit,
    output logic co
);

    bcd_t digit_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_reg <= '0;
        end else if (clr) begin
            digit_reg <= '0;
        end else if (en) begin
            if (digit_reg > MAX)
                digit_reg <= '0;
            else if (dir)
                digit_reg <= (digit_reg == 4'd0) ? MAX : digit_reg - 4'd1;
            else
                digit_reg <= (digit_reg == MAX) ? 4'd0 : digit_reg + 4'd1;
        end
    end

    // Independent of en so the top can AND these into a saturation test without a loop.
    assign co    = dir ? (digit_reg == 4'd0) : (digit_reg == MAX);
    assign digit = digit_reg;

endmodule

// File: rtl/stopwatch.sv
// Four-digit BCD stopwatch/timer (0:00.0 .. 9:59.9) with start/stop/clear and up/down count.
module stopwatch
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic Start,
    input  logic Stop,
    input  logic Clear,
    input  logic CountDown,
    output bcd_t Minutes,
    output bcd_t SecondsTens,
    output bcd_t SecondsOnes,
    output bcd_t TenthsOfSeconds
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             run_reg, run_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic             start_act, ctrl, tick, at_limit, step;
    logic [4:0]       en_chain;
    logic [3:0]       co;
    bcd_t             digit [4];

    // Start while running is ignored entirely, so it neither stalls the count nor resyncs the divider.
    assign start_act = Start && !run_reg;
    assign ctrl      = Clear || Stop || start_act;
    assign tick      = run_reg && (div_reg == DIV_LAST);
    assign at_limit  = &co;
    assign step      = tick && !ctrl && !at_limit;

    always_comb begin
        run_next = run_reg;
        div_next = div_reg;
        if (Clear)
            run_next = 1'b0;
        else if (Stop)
            run_next = 1'b0;
        else if (start_act)
            run_next = 1'b1;

        if (ctrl)
            div_next = '0;
        else if (run_reg)
            div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_reg <= 1'b0;
            div_reg <= '0;
        end else begin
            run_reg <= run_next;
            div_reg <= div_next;
        end
    end

    assign en_chain[0] = step;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            bcd_digit_counter #(.MAX(digit_max(gi))) u_digit (
                .clk   (clk),
                .reset (reset),
                .en    (en_chain[gi]),
                .dir   (CountDown),
                .clr   (Clear),
                .digit (digit[gi]),
                .co    (co[gi])
            );
            assign en_chain[gi+1] = en_chain[gi] && co[gi];
        end
    endgenerate

    assign TenthsOfSeconds = digit[0];
    assign SecondsOnes     = digit[1];
    assign SecondsTens     = digit[2];
    assign Minutes         = digit[3];

endmodule

// File: tb/tb_stopwatch.sv
// Directed checks of the stopwatch at CLK_DIV=1; display compared as packed BCD {M,ST,SO,T}.
module tb_stopwatch;
    import stopwatch_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic Start = 1'b0, Stop = 1'b0, Clear = 1'b0, CountDown = 1'b0;
    bcd_t Minutes, SecondsTens, SecondsOnes, TenthsOfSeconds;
    logic [15:0] disp;
    int total = 0;
    int bad = 0;

    stopwatch #(.CLK_DIV(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .Start           (Start),
        .Stop            (Stop),
        .Clear           (Clear),
        .CountDown       (CountDown),
        .Minutes         (Minutes),
        .SecondsTens     (SecondsTens),
        .SecondsOnes     (SecondsOnes),
        .TenthsOfSeconds (TenthsOfSeconds)
    );

    always #5 clk = ~clk;
    assign disp = {Minutes, SecondsTens, SecondsOnes, TenthsOfSeconds};

    // Advance n edges; inputs and samples land 1 time unit after the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        cyc(1);
        Start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        CountDown = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        cyc(1);
        reset = 1'b1;
        #1;
        total++;
        if (disp !== 16'h0000) begin bad++; $display("FAIL reset_async got=%h want=0000", disp); end
        cyc(20);
        total++;
        if (disp !== 16'h0000) begin bad++; $display("FAIL reset_hold got=%h want=0000", disp); end
        reset = 1'b0;
        cyc(10);
        total++;
        if (disp !== 16'h0000) begin bad++; $display("FAIL idle_no_count got=%h want=0000", disp); end
        $display("test_reset done");
    endtask

    task automatic test_count_up();
        pulse_start();
        total++;
        if (disp !== 16'h0000) begin bad++; $display("FAIL start_edge got=%h want=0000", disp); end
        cyc(1);
        total++;
        if (disp !== 16'h0001) begin bad++; $display("FAIL first_tick got=%h want=0001", disp); end
        cyc(98);
        total++;
        if (disp !== 16'h0099) begin bad++; $display("FAIL pre_carry got=%h want=0099", disp); end
        cyc(1);
        total++;
        if (disp !== 16'h0100) begin bad++; $display("FAIL carry_secs got=%h want=0100", disp); end
        cyc(499);
        total++;
        if (disp !== 16'h0599) begin bad++; $display("FAIL at_599 got=%h want=0599", disp); end
        cyc(1);
        total++;
        if (disp !== 16'h1000) begin bad++; $display("FAIL carry_min got=%h want=1000", disp); end
        $display("test_count_up done");
    endtask

    task automatic test_stop_hold();
        do_reset();
        pulse_start();
        cyc(599);
        Stop = 1'b1;
        cyc(1);
        Stop = 1'b0;
        total++;
        if (disp !== 16'h0599) begin bad++; $display("FAIL stop_edge got=%h want=0599", disp); end
        cyc(600);
        total++;
        if (disp !== 16'h0599) begin bad++; $display("FAIL stop_hold got=%h want=0599", disp); end
        reset = 1'b1;
        #1;
        total++;
        if (disp !== 16'h0000) begin bad++; $display("FAIL reset_mid got=%h want=0000", disp); end
        cyc(2);
        reset = 1'b0;
        cyc(1);
        $display("test_stop_hold done");
    endtask

    task automatic test_saturate_up();
        pulse_start();
        cyc(5990);
        total++;
        if (disp !== 16'h9590) begin bad++; $display("FAIL up_5990 got=%h want=9590", disp); end
        cyc(9);
        total++;
        if (disp !== 16'h9599) begin bad++; $display("FAIL up_max got=%h want=9599", disp); end
        cyc(20);
        total++;
        if (disp !== 16'h9599) begin bad++; $display("FAIL up_sat got=%h want=9599", disp); end
        $display("test_saturate_up done");
    endtask

    task automatic test_count_down();
        CountDown = 1'b1;
        cyc(4802);
        total++;
        if (disp !== 16'h1597) begin bad++; $display("FAIL down_4802 got=%h want=1597", disp); end
        cyc(597);
        total++;
        if (disp !== 16'h1000) begin bad++; $display("FAIL down_pre_borrow got=%h want=1000", disp); end
        cyc(1);
        total++;
        if (disp !== 16'h0599) begin bad++; $display("FAIL borrow_min got=%h want=0599", disp); end
        cyc(590);
        total++;
        if (disp !== 16'h0009) begin bad++; $display("FAIL down_0009 got=%h want=0009", disp); end
        cyc(9);
        total++;
        if (disp !== 16'h0000) begin bad++; $display("FAIL down_zero got=%h want=0000", disp); end
        cyc(20);
        total++;
        if (disp !== 16'h0000) begin bad++; $display("FAIL down_sat got=%h want=0000", disp); end
        // Saturated at zero with run still set: flipping direction resumes counting immediately.
        CountDown = 1'b0;
        cyc(3);
        total++;
        if (disp !== 16'h0003) begin bad++; $display("FAIL resume_up got=%h want=0003", disp); end
        CountDown = 1'b1;
        cyc(2);
        total++;
        if (disp !== 16'h0001) begin bad++; $display("FAIL toggle_down got=%h want=0001", disp); end
        $display("test_count_down done");
    endtask

    task automatic test_clear();
        do_reset();
        pulse_start();
        cyc(2014);
        total++;
        if (disp !== 16'h3214) begin bad++; $display("FAIL at_3214 got=%h want=3214", disp); end
        Clear = 1'b1;
        cyc(1);
        Clear = 1'b0;
        total++;
        if (disp !== 16'h0000) begin bad++; $display("FAIL clear got=%h want=0000", disp); end
        cyc(5);
        total++;
        if (disp !== 16'h0000) begin bad++; $display("FAIL clear_stopped got=%h want=0000", disp); end
        Start = 1'b1;
        Stop  = 1'b1;
        cyc(1);
        Start = 1'b0;
        Stop  = 1'b0;
        cyc(5);
        total++;
        if (disp !== 16'h0000) begin bad++; $display("FAIL start_stop got=%h want=0000", disp); end
        pulse_start();
        cyc(3);
        total++;
        if (disp !== 16'h0003) begin bad++; $display("FAIL restart got=%h want=0003", disp); end
        // Start while running changes nothing.
        Start = 1'b1;
        cyc(2);
        Start = 1'b0;
        total++;
        if (disp !== 16'h0005) begin bad++; $display("FAIL start_running got=%h want=0005", disp); end
        $display("test_clear done");
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_stop_hold();
        test_saturate_up();
        test_count_down();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
